fwd_scoreboard: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core, generalising the fixed two-stage MEM/WB forwarding scheme. It captures each issuing instruction's source and destination tags at ID/EX and shifts them through an internal tag pipeline that mirrors the datapath stages. From that pipeline it derives per-operand forwarding selects for EX and a load-use stall for ID. Operand count, forwarding depth and load-data availability stage are configurable.

---
 rtl/fwd_scoreboard.sv | 154 +++++++++++++++
 tb/tb_fwd_scoreboard.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding/load-use hazard unit: tracks in-flight dest tags, selects EX operand sources, stalls ID on load-use.
// Latency: tag accepted at edge t sits in EX in cycle t+1 and in S[k] in cycle t+1+k; fwd_sel_o is registered-state only.
// Backpressure: stall_o holds PC and IF/ID and injects a bubble into EX; flush_i squashes only the entry entering EX.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   id_valid_i / id_rd_addr_i / id_regwrite_i / id_memread_i   ID instruction tags
//   id_rs_addr_i, id_rs_used_i   ID source operands, operand j at [j*ADDR_W +: ADDR_W]
//   flush_i                      squash the instruction entering EX
//   stall_o                      load-use stall for ID (combinational)
//   fwd_sel_o                    per-operand select, 0 = register file, k = stage k result
//   stall_cnt_o                  saturating stall counter, present only with FWD_STALL_CNT_EN
module fwd_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [ADDR_W-1:0]          id_rd_addr_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_memread_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_rs_addr_i,
  input  logic [NUM_SRC-1:0]         id_rs_used_i,
  input  logic                       flush_i,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]                stall_cnt_o,
`endif
  output logic                       stall_o,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o
);

  // Entry 0 is EX, entries 1..DEPTH are the producer stages behind it.
  logic [DEPTH:0]             ent_valid_q, ent_valid_d;
  logic [DEPTH:0]             ent_regwrite_q, ent_regwrite_d;
  logic [DEPTH:0]             ent_memread_q, ent_memread_d;
  logic [DEPTH:0][ADDR_W-1:0] ent_rd_q, ent_rd_d;

  // Source tags only matter while the instruction is in EX.
  logic [NUM_SRC*ADDR_W-1:0]  ex_rs_q, ex_rs_d;
  logic [NUM_SRC-1:0]         ex_used_q, ex_used_d;

  logic [ADDR_W-1:0]          rs_fwd;
  logic [ADDR_W-1:0]          rs_id;
  logic                       accept;

  // Not every stage's load flag feeds the stall check; the full field is kept so the tag pipeline stays uniform.
  logic                       unused_memread;
  assign unused_memread = ^ent_memread_q;

  function automatic logic wr_match(input logic v, input logic rw,
                                    input logic [ADDR_W-1:0] rd,
                                    input logic [ADDR_W-1:0] a);
    return v && rw && (rd != '0) && (rd == a);
  endfunction

  // Load-use stall: a pending load still too young to forward its data.
  always_comb begin
    stall_o = 1'b0;
    rs_id   = '0;
    if (id_valid_i) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        rs_id = id_rs_addr_i[j*ADDR_W +: ADDR_W];
        if (id_rs_used_i[j] && (rs_id != '0)) begin
          for (int k = 0; k <= LOAD_STAGE - 2; k++) begin
            if (ent_memread_q[k] &&
                wr_match(ent_valid_q[k], ent_regwrite_q[k], ent_rd_q[k], rs_id))
              stall_o = 1'b1;
          end
        end
      end
    end
  end

  // Forward select: scan oldest to youngest so the youngest producer overwrites.
  always_comb begin
    fwd_sel_o = '0;
    rs_fwd    = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      rs_fwd = ex_rs_q[j*ADDR_W +: ADDR_W];
      if (ex_used_q[j] && (rs_fwd != '0)) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (wr_match(ent_valid_q[k], ent_regwrite_q[k], ent_rd_q[k], rs_fwd))
            fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // Tag pipeline advance; a stalled or flushed ID slot becomes a bubble in EX.
  always_comb begin
    accept         = id_valid_i && !stall_o && !flush_i;
    ent_valid_d    = '0;
    ent_regwrite_d = '0;
    ent_memread_d  = '0;
    ent_rd_d       = '0;
    ex_rs_d        = '0;
    ex_used_d      = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      ent_valid_d[k]    = ent_valid_q[k-1];
      ent_regwrite_d[k] = ent_regwrite_q[k-1];
      ent_memread_d[k]  = ent_memread_q[k-1];
      ent_rd_d[k]       = ent_rd_q[k-1];
    end
    if (accept) begin
      ent_valid_d[0]    = 1'b1;
      ent_regwrite_d[0] = id_regwrite_i;
      ent_memread_d[0]  = id_memread_i;
      ent_rd_d[0]       = id_rd_addr_i;
      ex_rs_d           = id_rs_addr_i;
      ex_used_d         = id_rs_used_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_valid_q    <= '0;
      ent_regwrite_q <= '0;
      ent_memread_q  <= '0;
      ent_rd_q       <= '0;
      ex_rs_q        <= '0;
      ex_used_q      <= '0;
    end else begin
      ent_valid_q    <= ent_valid_d;
      ent_regwrite_q <= ent_regwrite_d;
      ent_memread_q  <= ent_memread_d;
      ent_rd_q       <= ent_rd_d;
      ex_rs_q        <= ex_rs_d;
      ex_used_q      <= ex_used_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturates rather than wrapping so a long run never reads as few stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: instance A uses default parameters, instance B uses DEPTH=3, LOAD_STAGE=3.
// Each issued instruction pushes its expected EX-stage forward selects; they are popped one cycle later.
// Both instances share the ID inputs; only the instance selected by use_b is checked.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_rw;
  logic        id_mr;
  logic [9:0]  id_rs;
  logic [1:0]  id_used;
  logic        flush;

  logic        stall_a, stall_b;
  logic [3:0]  fwd_a, fwd_b;
  logic [31:0] cnt_a, cnt_b;

  int          n_checks = 0;
  int          n_err    = 0;
  logic        use_b    = 1'b0;
  logic [3:0]  exp_q[$];

  fwd_scoreboard dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rd_addr_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr), .id_rs_addr_i(id_rs),
    .id_rs_used_i(id_used), .flush_i(flush),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt_o(cnt_a),
`endif
    .stall_o(stall_a), .fwd_sel_o(fwd_a)
  );

  fwd_scoreboard #(.DEPTH(3), .LOAD_STAGE(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rd_addr_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr), .id_rs_addr_i(id_rs),
    .id_rs_used_i(id_used), .flush_i(flush),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt_o(cnt_b),
`endif
    .stall_o(stall_b), .fwd_sel_o(fwd_b)
  );

`ifndef FWD_STALL_CNT_EN
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rd = '0; id_rw = 1'b0; id_mr = 1'b0;
    id_rs = '0; id_used = '0; flush = 1'b0;
  endtask

  // Reset with random ID inputs; outputs must stay quiet throughout.
  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1;
    set_idle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      id_valid = 1'($urandom); id_rd = 5'($urandom); id_rw = 1'($urandom);
      id_mr = 1'($urandom); id_rs = 10'($urandom); id_used = 2'($urandom);
      flush = 1'($urandom);
      #1;
      check("rst_stall", use_b ? stall_b : stall_a, 0);
      check("rst_fwd", use_b ? fwd_b : fwd_a, 0);
    end
    rst = 1'b0;
    set_idle();
    exp_q.push_back(4'b0);
  endtask

  // One ID cycle: drive, check stall and the forward selects of whatever is in EX now,
  // then record what the next EX occupant should select.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic [4:0] rs0,
                     input logic [4:0] rs1, input logic [1:0] used, input logic fl,
                     input logic es, input logic [1:0] e0, input logic [1:0] e1);
    logic [3:0] e;
    @(negedge clk);
    id_valid = v; id_rd = rd; id_rw = rw; id_mr = mr;
    id_rs = {rs1, rs0}; id_used = used; flush = fl;
    #1;
    check({tag, "_stall"}, use_b ? stall_b : stall_a, es);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s_fwd: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_fwd"}, use_b ? fwd_b : fwd_a, e);
    end
    exp_q.push_back((v && !es && !fl) ? {e1, e0} : 4'b0);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();

    // ---------------- instance A: DEPTH=2, LOAD_STAGE=2 ----------------
    do_reset();
    //   tag        v  rd  rw mr  rs0 rs1 used fl  stall e0 e1
    cyc("add5",     1, 5,  1, 0,  1,  2,  3,   0,  0,    0, 0);
    cyc("sub_raw",  1, 6,  1, 0,  5,  1,  3,   0,  0,    1, 0);
    cyc("or_ind",   1, 8,  1, 0,  2,  3,  3,   0,  0,    0, 0);
    cyc("add10",    1, 10, 1, 0,  1,  2,  3,   0,  0,    0, 0);
    cyc("and11",    1, 11, 1, 0,  3,  4,  3,   0,  0,    0, 0);
    cyc("sub_gap1", 1, 12, 1, 0,  10, 1,  3,   0,  0,    2, 0);
    cyc("or_gap2",  1, 14, 1, 0,  10, 10, 3,   0,  0,    0, 0);
    // youngest producer wins
    cyc("add5b",    1, 5,  1, 0,  1,  2,  3,   0,  0,    0, 0);
    cyc("addi5",    1, 5,  1, 0,  1,  0,  1,   0,  0,    0, 0);
    cyc("and_pri",  1, 7,  1, 0,  5,  5,  3,   0,  0,    1, 1);
    // x0 and unused operands
    cyc("add_x0",   1, 0,  1, 0,  1,  2,  3,   0,  0,    0, 0);
    cyc("sub_x0",   1, 13, 1, 0,  0,  7,  1,   0,  0,    0, 0);
    cyc("lw_x0",    1, 0,  1, 1,  1,  0,  1,   0,  0,    0, 0);
    cyc("use_x0",   1, 15, 1, 0,  0,  0,  3,   0,  0,    0, 0);
    cyc("lw6a",     1, 6,  1, 1,  1,  0,  1,   0,  0,    0, 0);
    cyc("unused6",  1, 16, 1, 0,  1,  6,  1,   0,  0,    0, 0);
    // load-use: one stall cycle, then forward from stage 2
    cyc("lw6b",     1, 6,  1, 1,  2,  0,  1,   0,  0,    0, 0);
    cyc("lu_stall", 1, 7,  1, 0,  6,  0,  3,   0,  1,    0, 0);
    cyc("lu_go",    1, 7,  1, 0,  6,  0,  3,   0,  0,    2, 0);
    idle("lu_chk");
`ifdef FWD_STALL_CNT_EN
    check("cnt_a1", cnt_a, 1);
`endif
    // flush in the stall cycle
    cyc("lw6c",     1, 6,  1, 1,  1,  0,  1,   0,  0,    0, 0);
    cyc("fl_stall", 1, 7,  1, 0,  6,  0,  3,   1,  1,    0, 0);
    idle("fl_bub");
`ifdef FWD_STALL_CNT_EN
    check("cnt_a2", cnt_a, 2);
`endif
    // a flushed producer must not forward
    cyc("add20_fl", 1, 20, 1, 0,  1,  2,  3,   1,  0,    0, 0);
    cyc("sub20",    1, 21, 1, 0,  20, 1,  3,   0,  0,    0, 0);
    idle("fl_chk");
    // flush only squashes the entry entering EX; older producers still forward
    cyc("add22",    1, 22, 1, 0,  1,  2,  3,   0,  0,    0, 0);
    cyc("sub22_fl", 1, 23, 1, 0,  22, 22, 3,   1,  0,    0, 0);
    cyc("or22",     1, 24, 1, 0,  22, 0,  3,   0,  0,    2, 0);
    idle("old_chk");
    idle("drain_a");

    // ---------------- instance B: DEPTH=3, LOAD_STAGE=3 ----------------
    use_b = 1'b1;
    do_reset();
    cyc("b_lw6",    1, 6,  1, 1,  1,  0,  1,   0,  0,    0, 0);
    cyc("b_st1",    1, 7,  1, 0,  6,  0,  3,   0,  1,    0, 0);
    cyc("b_st2",    1, 7,  1, 0,  6,  0,  3,   0,  1,    0, 0);
    cyc("b_go",     1, 7,  1, 0,  6,  0,  3,   0,  0,    3, 0);
    idle("b_chk");
`ifdef FWD_STALL_CNT_EN
    check("cnt_b", cnt_b, 2);
`endif
    idle("drain_b");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
